// File: rtl/shared_access_requester.sv
// shared_access_requester: queues local commands and runs one arbiter handshake at a time.
// Latency: a command pushed into an empty FIFO while idle raises start_request one edge later; finish -> rsp_valid at the same edge.
// Backpressure: cmd_ready drops while the FIFO is full; rsp_ready low holds the response and stalls the next request.
//
// Ports:
//   sm_clk, reset                      clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_arg        local command push port
//   start_request, input_arguments     request side towards the arbiter port
//   reset_start_request, finish,       handshake and data returned by the arbiter
//   received_data
//   rsp_valid/rsp_ready/rsp_data       response port towards the local consumer
//   fifo_count, busy, protocol_error   status (queued commands, transaction active, sticky error)

// sar_cmd_fifo: small power-of-two FIFO holding queued command arguments.
// Latency: a pushed entry is visible at pop_dat one edge after the push.
// Backpressure: pushes while full and pops while empty are dropped.
module sar_cmd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   sm_clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge sm_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sm_clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module shared_access_requester #(
  parameter int N     = 32,
  parameter int M     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   sm_clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [N-1:0]           cmd_arg,
  output logic                   start_request,
  output logic [N-1:0]           input_arguments,
  input  logic                   reset_start_request,
  input  logic                   finish,
  input  logic [M-1:0]           received_data,
  output logic                   rsp_valid,
  output logic [M-1:0]           rsp_data,
  input  logic                   rsp_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   protocol_error
);
  typedef enum logic [1:0] {IDLE, REQUEST, WAIT_FINISH, RESPOND} state_t;

  state_t         state;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;
  logic [N-1:0]   head_arg;

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  sar_cmd_fifo #(.W(N), .DEPTH(DEPTH)) u_cmd_fifo (
    .sm_clk   (sm_clk),
    .reset    (reset),
    .push     (cmd_valid),
    .push_dat (cmd_arg),
    .pop      (fifo_pop),
    .pop_dat  (head_arg),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Handshake outputs are pure decodes of the state register, so they cannot glitch.
  assign start_request = (state == REQUEST);
  assign rsp_valid     = (state == RESPOND);
  assign busy          = (state != IDLE);

  always_ff @(posedge sm_clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      input_arguments <= '0;
      rsp_data        <= '0;
      protocol_error  <= 1'b0;
    end else begin
      // Arbiter pulses that arrive in the wrong phase are flagged and otherwise ignored.
      if ((finish && state != WAIT_FINISH) ||
          (reset_start_request && state != REQUEST))
        protocol_error <= 1'b1;

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            input_arguments <= head_arg;
            state           <= REQUEST;
          end
        end
        REQUEST: begin
          if (reset_start_request) state <= WAIT_FINISH;
        end
        WAIT_FINISH: begin
          if (finish) begin
            rsp_data <= received_data;
            state    <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_access_requester.sv
// tb_shared_access_requester: randomized bench with a transaction-level reference model.
// Latency: one model update per clock edge; outputs compared at every falling edge.
// Backpressure: the consumer randomly drops rsp_ready, and some phases force it low.
module tb_shared_access_requester;
  localparam int N     = 32;
  localparam int M     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          sm_clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_arg;
  logic          start_request;
  logic [N-1:0]  input_arguments;
  logic          reset_start_request;
  logic          finish;
  logic [M-1:0]  received_data;
  logic          rsp_valid;
  logic [M-1:0]  rsp_data;
  logic          rsp_ready;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          protocol_error;

  shared_access_requester #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
    .sm_clk              (sm_clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_arg             (cmd_arg),
    .start_request       (start_request),
    .input_arguments     (input_arguments),
    .reset_start_request (reset_start_request),
    .finish              (finish),
    .received_data       (received_data),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_ready           (rsp_ready),
    .fifo_count          (fifo_count),
    .busy                (busy),
    .protocol_error      (protocol_error)
  );

  always #5 sm_clk = ~sm_clk;

  int n_cmp;
  int n_err;

  // Reference model: pending commands, the command in flight and its progress.
  logic [N-1:0] q[$];
  bit           m_inflight;   // a command has been taken from the queue
  bit           m_acked;      // arbiter accepted the start request
  bit           m_rsp;        // response captured, waiting for consumer
  bit           m_perr;
  logic [N-1:0] m_arg;
  logic [M-1:0] m_data;

  // Arbiter and consumer knobs.
  int           arb_wait;
  int           req_lo, req_hi, fin_lo, fin_hi;
  bit           use_fixed;
  logic [M-1:0] fixed_val;
  int           rdy_pct;
  bit           hold_rdy_low;

  // Per-step stimulus requests.
  bit           want_push;
  logic [N-1:0] push_arg;
  bit           inj_fin;
  bit           inj_rsr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_inflight = 1'b0;
    m_acked    = 1'b0;
    m_rsp      = 1'b0;
    m_perr     = 1'b0;
    m_arg      = '0;
    m_data     = '0;
    arb_wait   = 0;
  endtask

  // Applies the spec rules for one clock edge, given the inputs driven for it.
  task automatic model_edge();
    bit can_push;
    can_push = cmd_valid && (q.size() != DEPTH);
    if (finish && !(m_inflight && m_acked && !m_rsp)) m_perr = 1'b1;
    if (reset_start_request && !(m_inflight && !m_acked)) m_perr = 1'b1;
    if (!m_inflight) begin
      if (q.size() != 0) begin
        m_arg      = q.pop_front();
        m_inflight = 1'b1;
        m_acked    = 1'b0;
        m_rsp      = 1'b0;
        arb_wait   = int'($urandom_range(req_hi, req_lo));
      end
    end else if (!m_acked) begin
      if (reset_start_request) begin
        m_acked  = 1'b1;
        arb_wait = int'($urandom_range(fin_hi, fin_lo));
      end
    end else if (!m_rsp) begin
      if (finish) begin
        m_rsp  = 1'b1;
        m_data = received_data;
      end
    end else if (rsp_ready) begin
      m_inflight = 1'b0;
      m_acked    = 1'b0;
      m_rsp      = 1'b0;
    end
    if (can_push) q.push_back(cmd_arg);
  endtask

  // One clock: compare at the falling edge, drive inputs, take the rising edge, update the model.
  task automatic step();
    bit a_rsr;
    bit a_fin;
    chk("start_request",   64'(start_request),   64'(m_inflight && !m_acked));
    chk("rsp_valid",       64'(rsp_valid),       64'(m_rsp));
    chk("busy",            64'(busy),            64'(m_inflight));
    chk("fifo_count",      64'(fifo_count),      64'(q.size()));
    chk("cmd_ready",       64'(cmd_ready),       64'(q.size() != DEPTH));
    chk("input_arguments", 64'(input_arguments), 64'(m_arg));
    chk("rsp_data",        64'(rsp_data),        64'(m_data));
    chk("protocol_error",  64'(protocol_error),  64'(m_perr));

    a_rsr = 1'b0;
    a_fin = 1'b0;
    if (m_inflight && !m_acked) begin
      if (arb_wait <= 0) a_rsr = 1'b1; else arb_wait--;
    end else if (m_inflight && !m_rsp) begin
      if (arb_wait <= 0) a_fin = 1'b1; else arb_wait--;
    end
    reset_start_request = a_rsr | inj_rsr;
    finish              = a_fin | inj_fin;
    received_data       = (a_fin && use_fixed) ? fixed_val : 8'($urandom);
    rsp_ready           = !hold_rdy_low && (int'($urandom_range(99)) < rdy_pct);
    cmd_valid           = want_push;
    cmd_arg             = want_push ? push_arg : 32'($urandom);

    @(posedge sm_clk);
    model_edge();
    @(negedge sm_clk);
    want_push = 1'b0;
    inj_fin   = 1'b0;
    inj_rsr   = 1'b0;
  endtask

  task automatic push_cmd(input logic [N-1:0] arg);
    want_push = 1'b1;
    push_arg  = arg;
    step();
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 600 && (m_inflight || q.size() != 0); i++) step();
    chk({tag, "_drain_timeout"}, 64'(m_inflight || q.size() != 0), 64'(0));
  endtask

  task automatic wait_rsp(input string tag);
    int i;
    for (i = 0; i < 200 && !m_rsp; i++) step();
    chk({tag, "_rsp_timeout"}, 64'(m_rsp), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] held;
    int           i;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_arg = '0;
    reset_start_request = 1'b0; finish = 1'b0; received_data = '0; rsp_ready = 1'b0;
    want_push = 1'b0; push_arg = '0; inj_fin = 1'b0; inj_rsr = 1'b0;
    hold_rdy_low = 1'b0; use_fixed = 1'b0; fixed_val = '0; rdy_pct = 50;
    req_lo = 0; req_hi = 3; fin_lo = 0; fin_hi = 3;
    model_reset();

    // Reset values.
    repeat (2) @(negedge sm_clk);
    chk("rst_cmd_ready",      64'(cmd_ready),       64'(1));
    chk("rst_start_request",  64'(start_request),   64'(0));
    chk("rst_rsp_valid",      64'(rsp_valid),       64'(0));
    chk("rst_fifo_count",     64'(fifo_count),      64'(0));
    chk("rst_busy",           64'(busy),            64'(0));
    chk("rst_input_args",     64'(input_arguments), 64'(0));
    chk("rst_protocol_error", 64'(protocol_error),  64'(0));
    reset = 1'b0;
    step();

    // Single command with fixed arbiter timing and data.
    req_lo = 1; req_hi = 1; fin_lo = 2; fin_hi = 2;
    use_fixed = 1'b1; fixed_val = 8'hA5;
    push_cmd(32'h0000_1234);
    wait_rsp("single");
    chk("single_arg",       64'(input_arguments), 64'(32'h1234));
    chk("single_rsp_data",  64'(rsp_data),        64'(8'hA5));
    chk("single_rsp_valid", 64'(rsp_valid),       64'(1));
    drain("single");
    chk("single_busy_after", 64'(busy), 64'(0));
    use_fixed = 1'b0;

    // Full FIFO while the arbiter stalls; second push lands on the pop edge.
    req_lo = 25; req_hi = 25;
    push_cmd(32'h1);
    push_cmd(32'h2);
    chk("pushpop_count", 64'(fifo_count),      64'(1));
    chk("pushpop_arg",   64'(input_arguments), 64'(32'h1));
    push_cmd(32'h3);
    push_cmd(32'h4);
    push_cmd(32'h5);
    chk("full_cmd_ready", 64'(cmd_ready),  64'(0));
    chk("full_count",     64'(fifo_count), 64'(4));
    push_cmd(32'h66);
    chk("full_ignored_count", 64'(fifo_count), 64'(4));
    req_lo = 0; req_hi = 3;
    drain("full");

    // Response backpressure with a second command queued.
    req_lo = 0; req_hi = 1; fin_lo = 0; fin_hi = 1;
    push_cmd(32'hAAAA_0001);
    push_cmd(32'hAAAA_0002);
    wait_rsp("bp");
    hold_rdy_low = 1'b1;
    held = m_data;
    repeat (10) step();
    chk("bp_rsp_data",  64'(rsp_data),      64'(held));
    chk("bp_count",     64'(fifo_count),    64'(1));
    chk("bp_no_req",    64'(start_request), 64'(0));
    chk("bp_rsp_valid", 64'(rsp_valid),     64'(1));
    hold_rdy_low = 1'b0;
    drain("bp");

    // Randomized traffic.
    req_lo = 0; req_hi = 4; fin_lo = 0; fin_hi = 4; rdy_pct = 60;
    for (i = 0; i < 1500; i++) begin
      want_push = ($urandom_range(99) < 40);
      push_arg  = $urandom;
      step();
    end
    drain("random");

    // Protocol errors: stray finish in idle, stray reset_start_request while waiting.
    inj_fin = 1'b1;
    step();
    step();
    chk("perr_set",    64'(protocol_error), 64'(1));
    chk("perr_no_rsp", 64'(rsp_valid),      64'(0));
    chk("perr_idle",   64'(busy),           64'(0));
    req_lo = 0; req_hi = 0; fin_lo = 20; fin_hi = 20;
    push_cmd(32'hC0DE);
    for (i = 0; i < 50 && !(m_inflight && m_acked); i++) step();
    chk("perr_wait_timeout", 64'(m_inflight && m_acked), 64'(1));
    inj_rsr = 1'b1;
    step();
    step();
    chk("perr_busy",   64'(busy),           64'(1));
    chk("perr_no_req", 64'(start_request),  64'(0));
    chk("perr_sticky", 64'(protocol_error), 64'(1));
    fin_lo = 0; fin_hi = 3;
    drain("perr");

    // Asynchronous reset in the middle of a transaction with three commands queued.
    req_lo = 0; req_hi = 0; fin_lo = 40; fin_hi = 40;
    push_cmd(32'h11);
    push_cmd(32'h22);
    push_cmd(32'h33);
    push_cmd(32'h44);
    for (i = 0; i < 50 && !(m_acked && q.size() == 3); i++) step();
    chk("arst_setup_timeout", 64'(m_acked && q.size() == 3), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("arst_start_request",  64'(start_request),  64'(0));
    chk("arst_rsp_valid",      64'(rsp_valid),      64'(0));
    chk("arst_fifo_count",     64'(fifo_count),     64'(0));
    chk("arst_busy",           64'(busy),           64'(0));
    chk("arst_cmd_ready",      64'(cmd_ready),      64'(1));
    chk("arst_protocol_error", 64'(protocol_error), 64'(0));
    model_reset();
    cmd_valid = 1'b0; finish = 1'b0; reset_start_request = 1'b0;
    @(negedge sm_clk);
    reset = 1'b0;

    req_lo = 1; req_hi = 2; fin_lo = 1; fin_hi = 2;
    use_fixed = 1'b1; fixed_val = 8'h3C;
    push_cmd(32'hBEEF);
    wait_rsp("post_rst");
    chk("post_rst_arg",  64'(input_arguments), 64'(32'hBEEF));
    chk("post_rst_data", 64'(rsp_data),        64'(8'h3C));
    drain("post_rst");
    use_fixed = 1'b0;

    // A stale finish after reset is reported.
    inj_fin = 1'b1;
    step();
    step();
    chk("stale_finish_perr", 64'(protocol_error), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shared_access_requester.md
# shared_access_requester

Requester-side client for the two-port shared-access arbiter that fronts a single target state machine (e.g. the flash read engine). It queues local commands in a small FIFO, runs the arbiter's start-request / reset-request / finish handshake one command at a time, captures the returned data word and presents it on a valid/ready response port. One instance sits on each arbiter port (a or b).

## Interface
- N, 32, argument width (matches the arbiter's argument bus)
- M, 8, returned data width
- DEPTH, 4, command FIFO depth; power of two, at least 2
- sm_clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd_valid  in  1  local command offered
- cmd_ready  out  1  FIFO not full; reset value 1
- cmd_arg  in  N  command argument
- start_request  out  1  to arbiter start_request_x; registered; reset 0
- input_arguments  out  N  to arbiter input_arguments_x; registered; reset 0
- reset_start_request  in  1  from arbiter: request taken, target started
- finish  in  1  from arbiter finish_x: one-cycle pulse, data valid
- received_data  in  M  from arbiter received_data_x
- rsp_valid  out  1  response available; reset 0
- rsp_data  out  M  captured data; reset 0
- rsp_ready  in  1  consumer accepts response
- fifo_count  out  $clog2(DEPTH)+1  commands queued (excludes in-flight); reset 0
- busy  out  1  FSM not in IDLE; reset 0
- protocol_error  out  1  sticky; reset 0

## Operation
- FIFO: push on cmd_valid && cmd_ready; cmd_ready = (fifo_count != DEPTH). Pointers wrap modulo DEPTH. cmd_valid while full is ignored, FIFO unchanged.
- FSM states: IDLE, REQUEST, WAIT_FINISH, RESPOND.
- IDLE: if fifo_count != 0, pop head into input_arguments, go REQUEST. Otherwise stay.
- REQUEST: start_request = 1. On reset_start_request = 1 go WAIT_FINISH; start_request is 0 from the next cycle.
- WAIT_FINISH: start_request = 0, input_arguments held. On finish = 1 register received_data into rsp_data, set rsp_valid, go RESPOND.
- RESPOND: rsp_valid = 1, rsp_data stable. On rsp_ready = 1 clear rsp_valid, go IDLE.
- start_request and rsp_valid are decoded from registered state (glitch-free).
- input_arguments changes only on the IDLE→REQUEST pop; stable through REQUEST and WAIT_FINISH.
- protocol_error sets on: finish = 1 outside WAIT_FINISH; reset_start_request = 1 outside REQUEST. The offending pulse is otherwise ignored. Cleared only by reset.
- Push and pop in the same cycle are allowed; fifo_count is unchanged.

## Timing
- Command accepted at edge t into an empty FIFO with FSM in IDLE: pop at edge t+1, start_request high from t+1.
- reset_start_request sampled high at edge r: start_request low from r; never high for more than one cycle after the arbiter's pulse.
- finish sampled high at edge f: rsp_valid and rsp_data valid from f.
- rsp_ready high at edge a while RESPOND: rsp_valid low from a; next pop no earlier than edge a+1.
- Minimum back-to-back command spacing: IDLE, REQUEST (≥1), WAIT_FINISH (≥1), RESPOND (≥1) = 4 cycles plus arbiter latency.
- reset asserted mid-transaction: all outputs go to reset values immediately, FIFO emptied, in-flight command and captured data discarded. The system resets the arbiter from the same reset. A later stale finish sets protocol_error.

## Test plan
- Single command: push cmd_arg=0x0000_1234; the arbiter model pulses reset_start_request 2 cycles after start_request rises and finish with received_data=0xA5 3 cycles later -> input_arguments=0x1234, rsp_data=0xA5, rsp_valid until rsp_ready, busy low after.
- Full FIFO: while the arbiter stalls, push 5 commands 0x1..0x5 with DEPTH=4 -> first pops, next 4 queue, cmd_ready low after the fifth push. Consumed in order 0x1..0x5 with responses matching the model.
- Backpressure: hold rsp_ready=0 for 10 cycles with 2 commands queued -> rsp_data held, no new start_request, fifo_count stays 1 until acceptance.
- Simultaneous push/pop: push at the edge the FSM pops from count=1 -> fifo_count stays 1, no lost or duplicate argument.
- Protocol error: pulse finish in IDLE -> protocol_error=1 sticky, no rsp_valid. Pulse reset_start_request in WAIT_FINISH -> no state change.
- Async reset: assert reset mid-cycle during WAIT_FINISH with 3 queued -> start_request, rsp_valid, fifo_count, busy are 0 before the next edge and cmd_ready=1. After release, a new command completes normally.
